// File: rtl/cr_xp10_decomp_be_chk_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cr_xp10_decomp_be_chk_arb
//  Purpose  : Frame-atomic round-robin arbiter that lets two decompressor
//             back-end sources share one frame checker. It forwards beats
//             of the granted source and routes the delayed checker result
//             back to the source that owned the frame. It also keeps
//             saturating per-source frame and error counters.
//  Ports    : clk, rst                   - clock, synchronous active-high reset
//             inN_valid/ready/data/bytes_valid/data_type - source N beat port
//             out_valid/ready/data/bytes_valid/data_type/src - checker port
//             chk_size_error, chk_crc_error - checker result, sampled
//                                          CHK_LAT cycles after an accepted EOF
//             errN_valid/size/crc        - per-source result pulse and flags
//             frmN_cnt, errN_cnt         - per-source frame / error counters
//  Revision : 1.0 - initial release
// ============================================================================
module cr_xp10_decomp_be_chk_arb #(
    parameter int CHK_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [63:0]      in0_data,
    input  logic [7:0]       in0_bytes_valid,
    input  logic [1:0]       in0_data_type,

    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [63:0]      in1_data,
    input  logic [7:0]       in1_bytes_valid,
    input  logic [1:0]       in1_data_type,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [7:0]       out_bytes_valid,
    output logic [1:0]       out_data_type,
    output logic             out_src,

    input  logic             chk_size_error,
    input  logic             chk_crc_error,

    output logic             err0_valid,
    output logic             err0_size,
    output logic             err0_crc,
    output logic             err1_valid,
    output logic             err1_size,
    output logic             err1_crc,

    output logic [CNT_W-1:0] frm0_cnt,
    output logic [CNT_W-1:0] err0_cnt,
    output logic [CNT_W-1:0] frm1_cnt,
    output logic [CNT_W-1:0] err1_cnt
);

    localparam logic [1:0]       C_TYPE_DATA = 2'b01;
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                      r_state_q, w_state_d;
    logic                        r_last_grant_q, w_last_grant_d;
    logic [CHK_LAT-1:0]          r_dl_vld_q, w_dl_vld_d;
    logic [CHK_LAT-1:0]          r_dl_src_q, w_dl_src_d;
    logic [1:0][CNT_W-1:0]       r_frm_cnt_q, w_frm_cnt_d;
    logic [1:0][CNT_W-1:0]       r_err_cnt_q, w_err_cnt_d;

    logic w_granted;
    logic w_sel_src;
    logic w_eof;
    logic w_emit;
    logic w_emit_src;

    // ------------------------------------------------------------------
    // Forwarding path. Outputs are forced quiet while rst is high so the
    // port is idle during reset, not only after the first reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_granted       = (r_state_q == GRANT0) || (r_state_q == GRANT1);
        w_sel_src       = (r_state_q == GRANT1);
        out_valid       = 1'b0;
        out_data        = '0;
        out_bytes_valid = '0;
        out_data_type   = '0;
        out_src         = 1'b0;
        in0_ready       = 1'b0;
        in1_ready       = 1'b0;
        if (!rst && w_granted) begin
            out_src = w_sel_src;
            if (w_sel_src) begin
                out_valid       = in1_valid;
                in1_ready       = out_ready;
                out_data        = in1_data;
                out_bytes_valid = in1_bytes_valid;
                out_data_type   = in1_data_type;
            end else begin
                out_valid       = in0_valid;
                in0_ready       = out_ready;
                out_data        = in0_data;
                out_bytes_valid = in0_bytes_valid;
                out_data_type   = in0_data_type;
            end
        end
        // Any non-data type closes the frame, including 2'b00 and 2'b11.
        w_eof = out_valid && out_ready && (out_data_type != C_TYPE_DATA);
    end

    // ------------------------------------------------------------------
    // Arbitration FSM: grant holds for a whole frame; the IDLE cycle
    // between frames is where the round-robin decision is made.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        case (r_state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    w_state_d = r_last_grant_q ? GRANT0 : GRANT1;
                end else if (in0_valid) begin
                    w_state_d = GRANT0;
                end else if (in1_valid) begin
                    w_state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (w_eof) begin
                    w_state_d      = IDLE;
                    w_last_grant_d = w_sel_src;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result delay line: one slot per cycle, so back-to-back frames each
    // get their own result without any stall.
    // ------------------------------------------------------------------
    always_comb begin
        w_dl_vld_d    = '0;
        w_dl_src_d    = '0;
        w_dl_vld_d[0] = w_eof;
        w_dl_src_d[0] = out_src;
        for (int i = 1; i < CHK_LAT; i++) begin
            w_dl_vld_d[i] = r_dl_vld_q[i-1];
            w_dl_src_d[i] = r_dl_src_q[i-1];
        end
    end

    assign w_emit     = r_dl_vld_q[CHK_LAT-1] && !rst;
    assign w_emit_src = r_dl_src_q[CHK_LAT-1];

    // Checker flags are only meaningful in the emerging slot.
    assign err0_valid = w_emit && !w_emit_src;
    assign err0_size  = err0_valid && chk_size_error;
    assign err0_crc   = err0_valid && chk_crc_error;
    assign err1_valid = w_emit && w_emit_src;
    assign err1_size  = err1_valid && chk_size_error;
    assign err1_crc   = err1_valid && chk_crc_error;

    // Saturating statistics counters.
    always_comb begin
        w_frm_cnt_d = r_frm_cnt_q;
        w_err_cnt_d = r_err_cnt_q;
        if (w_emit) begin
            if (r_frm_cnt_q[w_emit_src] != C_CNT_MAX) begin
                w_frm_cnt_d[w_emit_src] = r_frm_cnt_q[w_emit_src] + C_CNT_ONE;
            end
            if ((chk_size_error || chk_crc_error) &&
                (r_err_cnt_q[w_emit_src] != C_CNT_MAX)) begin
                w_err_cnt_d[w_emit_src] = r_err_cnt_q[w_emit_src] + C_CNT_ONE;
            end
        end
    end

    assign frm0_cnt = r_frm_cnt_q[0];
    assign frm1_cnt = r_frm_cnt_q[1];
    assign err0_cnt = r_err_cnt_q[0];
    assign err1_cnt = r_err_cnt_q[1];

    // ------------------------------------------------------------------
    // State registers. last_grant resets to 1 so source 0 wins the first
    // tie; clearing the delay line drops results of abandoned frames.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_last_grant_q <= 1'b1;
            r_dl_vld_q     <= '0;
            r_dl_src_q     <= '0;
            r_frm_cnt_q    <= '0;
            r_err_cnt_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_dl_vld_q     <= w_dl_vld_d;
            r_dl_src_q     <= w_dl_src_d;
            r_frm_cnt_q    <= w_frm_cnt_d;
            r_err_cnt_q    <= w_err_cnt_d;
        end
    end

    // A granted source whose beat is stalled must keep presenting it.
    a_hold_valid0: assert property (@(posedge clk) disable iff (rst)
        (r_state_q == GRANT0 && in0_valid && !out_ready) |=> in0_valid);
    a_hold_valid1: assert property (@(posedge clk) disable iff (rst)
        (r_state_q == GRANT1 && in1_valid && !out_ready) |=> in1_valid);

endmodule
`default_nettype wire

// File: tb/tb_cr_xp10_decomp_be_chk_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cr_xp10_decomp_be_chk_arb
//  Purpose  : Self-checking bench for cr_xp10_decomp_be_chk_arb: a directed
//             vector table, hand-written corner sequences and a random run
//             compared against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cr_xp10_decomp_be_chk_arb;

    localparam int CHK_LAT = 2;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid, in0_ready, in1_valid, in1_ready;
    logic [63:0]      in0_data, in1_data, out_data;
    logic [7:0]       in0_bytes_valid, in1_bytes_valid, out_bytes_valid;
    logic [1:0]       in0_data_type, in1_data_type, out_data_type;
    logic             out_valid, out_ready, out_src;
    logic             chk_size_error, chk_crc_error;
    logic             err0_valid, err0_size, err0_crc;
    logic             err1_valid, err1_size, err1_crc;
    logic [CNT_W-1:0] frm0_cnt, err0_cnt, frm1_cnt, err1_cnt;

    always #5 clk = ~clk;

    cr_xp10_decomp_be_chk_arb #(.CHK_LAT(CHK_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
        .in0_bytes_valid(in0_bytes_valid), .in0_data_type(in0_data_type),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .in1_bytes_valid(in1_bytes_valid), .in1_data_type(in1_data_type),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bytes_valid(out_bytes_valid), .out_data_type(out_data_type),
        .out_src(out_src),
        .chk_size_error(chk_size_error), .chk_crc_error(chk_crc_error),
        .err0_valid(err0_valid), .err0_size(err0_size), .err0_crc(err0_crc),
        .err1_valid(err1_valid), .err1_size(err1_size), .err1_crc(err1_crc),
        .frm0_cnt(frm0_cnt), .err0_cnt(err0_cnt),
        .frm1_cnt(frm1_cnt), .err1_cnt(err1_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    // ---------------- reference model (frame level) ----------------
    int m_owner;              // -1: nobody owns the port, else source index
    int m_last;               // source that completed the most recent frame
    int m_pipe[CHK_LAT];      // -1 empty, else source of an awaiting result
    int m_frm[2];
    int m_err[2];
    bit m_acc[2];

    // DUT outputs captured at the last checking edge
    logic s_out_valid, s_out_src, s_rdy0, s_rdy1, s_ev0;
    logic [63:0] s_out_data;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        for (int i = 0; i < CHK_LAT; i++) m_pipe[i] = -1;
        m_frm = '{0, 0};
        m_err = '{0, 0};
        m_acc = '{1'b0, 1'b0};
    endtask

    // One clock: drive, check at negedge against the model, advance model.
    task automatic step(input bit v0, input logic [1:0] t0, input logic [63:0] d0,
                        input bit v1, input logic [1:0] t1, input logic [63:0] d1,
                        input bit ordy, input bit csz, input bit ccrc, input bit r);
        int head;
        bit exp_ov, eof;
        rst = r;
        in0_valid = v0; in0_data_type = t0; in0_data = d0; in0_bytes_valid = d0[63:56];
        in1_valid = v1; in1_data_type = t1; in1_data = d1; in1_bytes_valid = d1[63:56];
        out_ready = ordy; chk_size_error = csz; chk_crc_error = ccrc;
        @(negedge clk);
        s_out_valid = out_valid; s_out_src = out_src; s_out_data = out_data;
        s_rdy0 = in0_ready; s_rdy1 = in1_ready; s_ev0 = err0_valid;
        if (r) begin
            chk("rst_port", {out_valid, in0_ready, in1_ready}, 3'b000);
            chk("rst_err", {err0_valid, err0_size, err0_crc, err1_valid, err1_size, err1_crc}, 6'b0);
            m_acc = '{1'b0, 1'b0};
        end else begin
            exp_ov = (m_owner == 0) ? v0 : (m_owner == 1) ? v1 : 1'b0;
            chk("out_valid", out_valid, exp_ov);
            chk("in0_ready", in0_ready, (m_owner == 0) ? ordy : 1'b0);
            chk("in1_ready", in1_ready, (m_owner == 1) ? ordy : 1'b0);
            if (exp_ov) begin
                chk("out_src", out_src, m_owner);
                chk("out_data", out_data, (m_owner == 0) ? d0 : d1);
                chk("out_bytes_type", {out_bytes_valid, out_data_type},
                    (m_owner == 0) ? {d0[63:56], t0} : {d1[63:56], t1});
            end
            head = m_pipe[CHK_LAT-1];
            chk("err0", {err0_valid, err0_size, err0_crc}, (head == 0) ? {1'b1, csz, ccrc} : 3'b000);
            chk("err1", {err1_valid, err1_size, err1_crc}, (head == 1) ? {1'b1, csz, ccrc} : 3'b000);
            chk("frm0_cnt", frm0_cnt, m_frm[0]);
            chk("err0_cnt", err0_cnt, m_err[0]);
            chk("frm1_cnt", frm1_cnt, m_frm[1]);
            chk("err1_cnt", err1_cnt, m_err[1]);
            // advance the model by one clock
            m_acc[0] = (m_owner == 0) && v0 && ordy;
            m_acc[1] = (m_owner == 1) && v1 && ordy;
            eof = (m_acc[0] && t0 != 2'b01) || (m_acc[1] && t1 != 2'b01);
            if (head >= 0) begin
                m_frm[head] = sat(m_frm[head] + 1);
                if (csz || ccrc) m_err[head] = sat(m_err[head] + 1);
            end
            for (int i = CHK_LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = eof ? m_owner : -1;
            if (m_owner < 0) begin
                if (v0 && v1)  m_owner = 1 - m_last;
                else if (v0)   m_owner = 0;
                else if (v1)   m_owner = 1;
            end else if (eof) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        if (r) model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 0, 0, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit v0, v1;
        logic [1:0] t0, t1;
        bit ordy, csz, ccrc;
        bit e_ov, e_src, e_r0, e_r1;
        logic [2:0] e_err0, e_err1;
    } vec_t;

    vec_t tbl[15];

    // random-phase source state
    bit          cv[2];
    logic [1:0]  ct[2];
    logic [63:0] cd[2];
    bit          r_rand, ordy_rand;
    int          n_beats, k;
    logic [63:0] d_hold, d0, d1;

    function automatic logic [1:0] rnd_type();
        int sel;
        sel = $urandom_range(0, 2);
        if ($urandom_range(0, 2) != 0) return 2'b01;
        return (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
    endfunction

    initial begin
        model_reset();
        step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 1, 1, 1);
        step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 1, 1, 1);

        // tie -> src0, then src1; interleaved 3-beat frames; error routing
        //            v0 v1 t0     t1     rdy sz crc  ov src r0 r1 err0    err1
        tbl[0]  = '{1, 1, 2'b01, 2'b01, 1, 1, 1,  0, 0, 0, 0, 3'b000, 3'b000};
        tbl[1]  = '{1, 1, 2'b01, 2'b01, 1, 1, 1,  1, 0, 1, 0, 3'b000, 3'b000};
        tbl[2]  = '{1, 1, 2'b01, 2'b01, 1, 0, 0,  1, 0, 1, 0, 3'b000, 3'b000};
        tbl[3]  = '{1, 1, 2'b10, 2'b01, 1, 1, 1,  1, 0, 1, 0, 3'b000, 3'b000};
        tbl[4]  = '{0, 1, 2'b01, 2'b01, 1, 0, 1,  0, 0, 0, 0, 3'b000, 3'b000};
        tbl[5]  = '{0, 1, 2'b01, 2'b01, 1, 1, 0,  1, 1, 0, 1, 3'b110, 3'b000};
        tbl[6]  = '{0, 1, 2'b01, 2'b01, 1, 1, 1,  1, 1, 0, 1, 3'b000, 3'b000};
        tbl[7]  = '{0, 1, 2'b01, 2'b11, 1, 1, 1,  1, 1, 0, 1, 3'b000, 3'b000};
        tbl[8]  = '{0, 0, 2'b01, 2'b01, 1, 1, 1,  0, 0, 0, 0, 3'b000, 3'b000};
        tbl[9]  = '{0, 0, 2'b01, 2'b01, 1, 0, 1,  0, 0, 0, 0, 3'b000, 3'b101};
        tbl[10] = '{0, 1, 2'b01, 2'b10, 1, 1, 1,  0, 0, 0, 0, 3'b000, 3'b000};
        tbl[11] = '{0, 1, 2'b01, 2'b10, 1, 1, 1,  1, 1, 0, 1, 3'b000, 3'b000};
        tbl[12] = '{0, 0, 2'b01, 2'b01, 1, 1, 1,  0, 0, 0, 0, 3'b000, 3'b000};
        tbl[13] = '{0, 0, 2'b01, 2'b01, 1, 0, 1,  0, 0, 0, 0, 3'b000, 3'b101};
        tbl[14] = '{0, 0, 2'b01, 2'b01, 1, 1, 1,  0, 0, 0, 0, 3'b000, 3'b000};

        for (int i = 0; i < 15; i++) begin
            d0 = {8'hA0 + 8'(i), 56'h0A0A_0000_0000 + 56'(i)};
            d1 = {8'hB0 + 8'(i), 56'h0B0B_0000_0000 + 56'(i)};
            rst = 0;
            in0_valid = tbl[i].v0; in0_data_type = tbl[i].t0; in0_data = d0; in0_bytes_valid = d0[63:56];
            in1_valid = tbl[i].v1; in1_data_type = tbl[i].t1; in1_data = d1; in1_bytes_valid = d1[63:56];
            out_ready = tbl[i].ordy; chk_size_error = tbl[i].csz; chk_crc_error = tbl[i].ccrc;
            @(negedge clk);
            chk($sformatf("tbl%0d_port", i), {out_valid, in0_ready, in1_ready},
                {tbl[i].e_ov, tbl[i].e_r0, tbl[i].e_r1});
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_src", i), out_src, tbl[i].e_src);
                chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_src ? d1 : d0);
            end
            chk($sformatf("tbl%0d_err", i), {err0_valid, err0_size, err0_crc, err1_valid, err1_size, err1_crc},
                {tbl[i].e_err0, tbl[i].e_err1});
            @(posedge clk);
            #1;
        end
        chk("tbl_counters", {frm0_cnt, err0_cnt, frm1_cnt, err1_cnt}, {2'd1, 2'd1, 2'd2, 2'd2});

        // ---- frame atomicity: src1 raises valid mid-frame of src0 ----
        step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 0, 0, 1);
        step(1, 2'b01, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        step(1, 2'b01, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        d1 = rnd64();
        for (int i = 0; i < 3; i++) begin
            step(1, (i == 2) ? 2'b10 : 2'b01, rnd64(), 1, 2'b10, d1, 1, 0, 0, 0);
            chk("atom_in1_ready_low", s_rdy1, 1'b0);
        end
        step(0, 2'b01, 64'h0, 1, 2'b10, d1, 1, 0, 0, 0);
        chk("atom_bubble", s_out_valid, 1'b0);
        step(0, 2'b01, 64'h0, 1, 2'b10, d1, 1, 0, 0, 0);
        chk("atom_grant1", {s_out_valid, s_out_src, s_rdy1}, 3'b111);
        idle(3);

        // ---- backpressure: 4-cycle stall mid-frame ----
        n_beats = 0;
        step(1, 2'b01, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        step(1, 2'b01, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        n_beats += int'(s_out_valid);
        d_hold = rnd64();
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b01, d_hold, i[0], 2'b01, rnd64(), 0, 0, 0, 0);
            chk("bp_payload", s_out_data, d_hold);
            chk("bp_grant", {s_out_valid, s_out_src, s_rdy0}, 3'b100);
        end
        step(1, 2'b01, d_hold, 0, 2'b01, 64'h0, 1, 0, 0, 0);
        n_beats += int'(s_out_valid);
        step(1, 2'b10, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        n_beats += int'(s_out_valid);
        idle(1);
        chk("bp_beats", n_beats, 3);
        idle(3);

        // ---- saturation (CNT_W=2) and reset with a result in flight ----
        step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 0, 0, 1);
        for (int f = 0; f < 5; f++) begin
            step(1, 2'b10, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
            step(1, 2'b10, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        end
        idle(3);
        chk("sat_frm0", frm0_cnt, 2'd3);
        step(1, 2'b10, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        step(1, 2'b10, rnd64(), 0, 2'b01, 64'h0, 1, 0, 0, 0);
        step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 2'b01, 64'h0, 0, 2'b01, 64'h0, 1, 1, 1, 0);
            chk("rst_no_pulse", s_ev0, 1'b0);
        end
        chk("rst_counters", {frm0_cnt, err0_cnt}, 4'b0);

        // ---- randomized run against the model ----
        for (int s = 0; s < 2; s++) begin
            cv[s] = 1'b0; ct[s] = rnd_type(); cd[s] = rnd64();
        end
        for (int c = 0; c < 4000; c++) begin
            r_rand    = ($urandom_range(0, 299) == 0);
            ordy_rand = ($urandom_range(0, 3) != 0);
            step(cv[0], ct[0], cd[0], cv[1], ct[1], cd[1], ordy_rand,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_rand);
            for (int s = 0; s < 2; s++) begin
                if (m_acc[s]) begin
                    cv[s] = ($urandom_range(0, 3) != 0);
                    ct[s] = rnd_type();
                    cd[s] = rnd64();
                end else if (!(m_owner == s && cv[s] && !r_rand)) begin
                    cv[s] = 1'($urandom_range(0, 1));
                    k = $urandom_range(0, 1);
                    if (k == 1) cd[s] = rnd64();
                end
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cr_xp10_decomp_be_chk_arb.md
CR_XP10_DECOMP_BE_CHK_ARB -- requirements
Module: cr_xp10_decomp_be_chk_arb

Interface
REQ-001 Parameter: CHK_LAT, default 2, cycles from an accepted end-of-frame beat on the checker port to the valid size_error/crc_error sample.
REQ-002 Parameter: CNT_W, default 16, width of the per-source statistics counters.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 inN_valid / inN_ready  input / output  1 / 1  beat handshake for source N (N = 0, 1).
REQ-006 inN_data / inN_bytes_valid / inN_data_type  input  64 / 8 / 2  beat payload for source N; data_type 2'b01 = frame data, any other value = end of frame.
REQ-007 out_valid / out_ready  output / input  1 / 1  beat handshake on the shared frame-check port.
REQ-008 out_data / out_bytes_valid / out_data_type  output  64 / 8 / 2  forwarded beat payload.
REQ-009 out_src  output  1  source index of the forwarded beat.
REQ-010 chk_size_error / chk_crc_error  input  1 / 1  result from the shared checker.
REQ-011 errN_valid / errN_size / errN_crc  output  1 / 1 / 1  per-source frame result pulse and error flags.
REQ-012 frmN_cnt / errN_cnt  output  CNT_W / CNT_W  per-source count of completed frames and of erroneous frames.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-014 In IDLE with exactly one inN_valid asserted, the FSM SHALL move to GRANTN on the next cycle.
REQ-015 In IDLE with both valid, the FSM SHALL grant the source that is not last_grant (round robin).
REQ-016 In IDLE with no valid, the FSM SHALL stay in IDLE.
REQ-017 No beat SHALL be forwarded in an IDLE cycle; each frame therefore carries a one-cycle arbitration bubble.
REQ-018 In GRANTN, the forwarding path SHALL be:
  - out_valid = inN_valid;
  - inN_ready = out_ready;
  - payload and out_src = N, combinational pass-through;
  - in(1-N)_ready = 0.
REQ-019 Grant SHALL be frame-atomic: an accepted beat in GRANTN with data_type != 2'b01 SHALL return the FSM to IDLE next cycle and set last_grant = N.
REQ-020 Data beats SHALL keep the FSM in GRANTN.
REQ-021 A single-beat frame (the first beat is end of frame) SHALL be legal.
REQ-022 On every accepted end-of-frame beat, {1, out_src} SHALL enter a CHK_LAT-deep delay line.
REQ-023 When an entry emerges from the delay line, for its source:
  - errN_valid SHALL pulse 1 cycle;
  - errN_size = chk_size_error and errN_crc = chk_crc_error on that cycle;
  - frmN_cnt SHALL increment;
  - errN_cnt SHALL increment if either error is set.
REQ-024 Outside an emerging delay-line slot, errN_valid, errN_size and errN_crc SHALL be 0; checker error inputs are ignored at all other times.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Back-to-back frames (end of frame on consecutive accept slots, separated by the bubble) SHALL each produce exactly one result pulse; the delay line is fully pipelined.
REQ-027 out_ready low SHALL stall the forwarded beat with the payload held; grant SHALL be kept while stalled.
REQ-028 While stalled, inN_valid SHALL be required to stay high (source protocol); deassertion is a protocol violation flagged by assertion.
REQ-029 Only the granted source's input SHALL affect the outputs while in GRANTN.
REQ-030 The other source's valid MAY toggle freely without effect.

Reset
REQ-031 While rst is high, the block SHALL hold:
  - FSM in IDLE, last_grant = 1 (source 0 wins the first tie);
  - delay line cleared;
  - all counters 0;
  - out_valid, inN_ready and errN_* at 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame and discard in-flight results; no errN_valid pulse for that frame SHALL be emitted after reset.

Verification
REQ-033 Tie: both sources valid in IDLE after reset -> source 0 granted first.
REQ-034 Tie with interleaved bytes: each source sends a 3-beat frame -> source 1 granted next, out_src sequence 0,0,0,1,1,1 with one bubble between frames.
REQ-035 Error return: source 1 single-beat frame with data_type 2'b10, chk_crc_error=1 at CHK_LAT=2 -> err1_valid=1 and err1_crc=1 two cycles after accept; frm1_cnt=1, err1_cnt=1; err0_valid stays 0.
REQ-036 Frame atomicity: source 0 frame in progress, source 1 asserts valid mid-frame -> in1_ready stays 0 until the source 0 end of frame is accepted, then source 1 is granted after one IDLE cycle.
REQ-037 Backpressure: out_ready low 4 cycles mid-frame -> payload stable, no beat lost or duplicated, grant unchanged.
REQ-038 Saturation and reset: with CNT_W=2, five clean frames -> frm0_cnt=3; reset asserted during an outstanding result -> no pulse, counters 0.
